clk_mon: RTL and testbench
==========================

# clk_mon

Clock/reset health monitor and soft-reset responder on the Wishbone bus. It consumes the clocks and lock status the clock generation unit produces:
- measures the SDRAM clock frequency against the Wishbone clock;
- counts DCM lock-loss events and raises an interrupt on each;
- lets software request a timed reset pulse that feeds back into the clock/reset tree.

It sits as a small Wishbone B3 classic slave next to the clock generation unit.

## Interface
Parameters:
- GATE_CYCLES, 1024: length of one measurement window, in wb_clk_o cycles.
- CNT_W, 16: width of the measured-clock counter and of the FREQ result.
- SWRST_CYCLES, 16: duration of the soft-reset pulse, in wb_clk_o cycles.

Ports:
- wb_clk_o  in  1  Wishbone clock; every register in the block except the measured-clock counter runs on it.
- async_rst_o  in  1  reset, asynchronous, active-high; also resets the meas_clk_i counter.
- meas_clk_i  in  1  clock under measurement (SDRAM clock).
- locked_i  in  1  DCM locked flag, asynchronous to wb_clk_o.
- wb_adr_i  in  2  word address (byte address bits [3:2]).
- wb_dat_i  in  32  write data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  lock-loss interrupt, level.
- sw_rst_o  out  1  software reset request, active-high.

## Operation
Register map (unused bits read 0; writes to RO registers are ignored):
- 0x0 STATUS:
  - [0] locked (synchronized), RO.
  - [1] freq_valid, RO.
  - [2] irq_pending, W1C.
  - [3] sw_rst active, RO.
  - [15:8] loss_cnt, RO.
- 0x4 FREQ: [CNT_W-1:0] meas_clk_i edges counted in the last completed window, RO.
- 0x8 CTRL: writing 1 to bit [0] starts a soft reset; the bit reads 0.
- 0xC ID: constant 0x434B4D31, RO.

Lock monitor:
- locked_i passes through a 2-FF synchronizer.
- A 1→0 transition of the synchronized value increments loss_cnt, saturating at 255, and sets irq_pending.
- irq_o = irq_pending.
- If a lock loss and a W1C of irq_pending land in the same cycle, set wins.

Frequency measurement:
- A free-running CNT_W-bit binary counter runs in the meas_clk_i domain and is converted to Gray code in a register.
- The Gray value crosses into wb_clk_o through a 2-FF synchronizer and is converted back to binary.
- A gate counter runs 0..GATE_CYCLES-1 on wb_clk_o. At the terminal count:
  - snap is captured;
  - FREQ = snap − prev_snap, modulo 2^CNT_W;
  - prev_snap ← snap.
- freq_valid sets at the end of the second window; until then FREQ stays 0.
- Results are correct only while f_meas/f_wb < 2^CNT_W/GATE_CYCLES (64 with the defaults). Above that the count wraps silently.

Soft reset:
- A CTRL write with bit0=1 loads a down-counter with SWRST_CYCLES.
- sw_rst_o = (counter ≠ 0).
- Rewriting while the pulse is active reloads the counter, extending the pulse.

## Timing
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, irq_o=0, sw_rst_o=0;
  - loss_cnt=0, FREQ=0, freq_valid=0;
  - gate counter=0, meas counter=0.
- Wishbone: wb_ack_o = registered (wb_cyc_i & wb_stb_i & ~wb_ack_o). It is therefore one cycle after the request and never asserted in two consecutive cycles.
  - Read data is valid in the ack cycle.
  - Register writes take effect on the same clock edge that asserts ack.
- sw_rst_o goes high on the edge that asserts ack for the CTRL write and stays high exactly SWRST_CYCLES cycles.
- Lock-loss latency: irq_o rises 3 wb_clk_o cycles after locked_i falls, ±1 for synchronizer phase.
- Synchronizer latency is constant, so it cancels in the FREQ difference. Measurement error is ±1 count.
- Async reset during a soft-reset pulse ends the pulse immediately. During a window, it restarts measurement and clears freq_valid.

## Structure
- Shared package `clk_mon_pkg` holds:
  - register offsets (STATUS, FREQ, CTRL, ID);
  - STATUS bit positions;
  - the ID constant.
- Sub-module `clk_mon_gray_sync` (parameter CNT_W) contains:
  - the meas_clk_i binary counter and Gray encoder;
  - the 2-FF synchronizer;
  - the Gray-to-binary decoder.
  - Its output is the binary count in the wb_clk_o domain.
- The top contains the Wishbone decode, lock monitor, gate counter and soft-reset counter.

## Test plan
- meas_clk_i = 2× wb_clk_o, defaults → after two windows, FREQ reads 2048 ±1 and STATUS[1]=1.
- Toggle locked_i 1→0 three times → loss_cnt=3 and irq_o=1; W1C STATUS bit2 → irq_o=0 and loss_cnt stays 3.
- Write CTRL=1 → sw_rst_o high for exactly 16 cycles; a second write at cycle 10 extends the pulse to end at cycle 26.
- Hold cyc/stb for 6 cycles → wb_ack_o toggles 0,1,0,1,0,1; read ID returns 0x434B4D31.
- Run 300 lock losses → loss_cnt saturates at 255; a W1C in the same cycle as a loss leaves irq_pending=1.
- Assert async_rst_o mid-window and mid-pulse → all outputs return to reset values on the next sample; FREQ=0 and freq_valid=0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock/reset health monitor: register map,
// STATUS bit positions and the block identification constant.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_FREQ   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_ID     = 2'd3
    } reg_adr_e;

    localparam int ST_LOCKED     = 0;
    localparam int ST_FREQ_VALID = 1;
    localparam int ST_IRQ        = 2;
    localparam int ST_SWRST      = 3;
    localparam int ST_LOSS_LSB   = 8;

    localparam logic [31:0] CLK_MON_ID = 32'h434B4D31;

endpackage

// File: rtl/clk_mon_gray_sync.sv
// Free-running counter on the measured clock, carried into the Wishbone
// clock domain as Gray code and decoded back to binary there.
module clk_mon_gray_sync #(
    parameter int CNT_W = 16
) (
    input  logic             i_meas_clk,
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_bin;
    logic [CNT_W-1:0] r_gray;
    logic [CNT_W-1:0] r_sync1;
    logic [CNT_W-1:0] r_sync2;
    logic [CNT_W-1:0] w_bin;

    // Gray register trails the binary counter by one edge; only one bit changes per step.
    always_ff @(posedge i_meas_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= r_bin + 1'b1;
            r_gray <= r_bin ^ (r_bin >> 1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= r_gray;
            r_sync2 <= r_sync1;
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_gray2bin
            assign w_bin[gi] = ^r_sync2[CNT_W-1:gi];
        end
    endgenerate

    assign o_count = w_bin;

endmodule

// File: rtl/clk_mon.sv
// Clock/reset health monitor: Wishbone register slave, DCM lock-loss counter
// with interrupt, gated frequency measurement and timed soft-reset pulse.
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = 1024,
    parameter int CNT_W        = 16,
    parameter int SWRST_CYCLES = 16
) (
    input  logic        wb_clk_o,
    input  logic        async_rst_o,
    input  logic        meas_clk_i,
    input  logic        locked_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o,
    output logic        sw_rst_o
);

    localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SWRST_W = $clog2(SWRST_CYCLES + 1);

    logic               r_ack;
    logic [31:0]        r_dat;
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic               r_lock_prev;
    logic               r_irq;
    logic [7:0]         r_loss_cnt;
    logic [GATE_W-1:0]  r_gate;
    logic               r_have_prev;
    logic [CNT_W-1:0]   r_prev;
    logic [CNT_W-1:0]   r_freq;
    logic               r_freq_valid;
    logic [SWRST_W-1:0] r_swrst_cnt;

    logic               w_req;
    logic               w_wr;
    reg_adr_e           w_adr;
    logic               w_status_wr;
    logic               w_ctrl_wr;
    logic               w_loss;
    logic               w_gate_tc;
    logic               w_swrst_active;
    logic [CNT_W-1:0]   w_count;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused;

    clk_mon_gray_sync #(
        .CNT_W (CNT_W)
    ) u_gray_sync (
        .i_meas_clk (meas_clk_i),
        .i_clk      (wb_clk_o),
        .i_rst      (async_rst_o),
        .o_count    (w_count)
    );

    // A request is accepted only when no ack is outstanding, so ack never repeats back to back.
    assign w_req          = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr           = w_req & wb_we_i;
    assign w_adr          = reg_adr_e'(wb_adr_i);
    assign w_status_wr    = w_wr & (w_adr == REG_STATUS);
    assign w_ctrl_wr      = w_wr & (w_adr == REG_CTRL);
    assign w_loss         = r_lock_prev & ~r_lock_sync;
    assign w_gate_tc      = (r_gate == GATE_W'(GATE_CYCLES - 1));
    assign w_swrst_active = (r_swrst_cnt != '0);
    assign w_unused       = &{1'b0, wb_dat_i[31:3], wb_dat_i[1]};

    always_comb begin
        w_status                    = '0;
        w_status[ST_LOCKED]         = r_lock_sync;
        w_status[ST_FREQ_VALID]     = r_freq_valid;
        w_status[ST_IRQ]            = r_irq;
        w_status[ST_SWRST]          = w_swrst_active;
        w_status[ST_LOSS_LSB +: 8]  = r_loss_cnt;
    end

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            REG_STATUS: w_rdata = w_status;
            REG_FREQ:   w_rdata = 32'(r_freq);
            REG_CTRL:   w_rdata = '0;
            REG_ID:     w_rdata = CLK_MON_ID;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
        if (async_rst_o) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : '0;
        end
    end

    // Lock monitor: a loss in the same cycle as a W1C keeps the interrupt pending.
    always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
        if (async_rst_o) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_lock_prev <= 1'b0;
            r_irq       <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_lock_meta <= locked_i;
            r_lock_sync <= r_lock_meta;
            r_lock_prev <= r_lock_sync;
            if (w_loss)
                r_irq <= 1'b1;
            else if (w_status_wr && wb_dat_i[ST_IRQ])
                r_irq <= 1'b0;
            if (w_loss && (r_loss_cnt != 8'hFF))
                r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    // The first window only seeds prev_snap; a result is published from the second on.
    always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
        if (async_rst_o) begin
            r_gate       <= '0;
            r_have_prev  <= 1'b0;
            r_prev       <= '0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
        end else begin
            if (w_gate_tc) begin
                r_gate      <= '0;
                r_prev      <= w_count;
                r_have_prev <= 1'b1;
                if (r_have_prev) begin
                    r_freq       <= w_count - r_prev;
                    r_freq_valid <= 1'b1;
                end
            end else begin
                r_gate <= r_gate + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
        if (async_rst_o)
            r_swrst_cnt <= '0;
        else if (w_ctrl_wr && wb_dat_i[0])
            r_swrst_cnt <= SWRST_W'(SWRST_CYCLES);
        else if (w_swrst_active)
            r_swrst_cnt <= r_swrst_cnt - 1'b1;
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;
    assign sw_rst_o = w_swrst_active;

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: bus reads are checked through a scoreboard of
// expected values, pins are checked directly at negedge sample points.
module tb_clk_mon;

    localparam int GATE  = 1024;
    localparam int CNT_W = 16;
    localparam int SWRST = 16;

    logic        wb_clk_o    = 1'b0;
    logic        meas_clk_i  = 1'b0;
    logic        async_rst_o = 1'b1;
    logic        locked_i    = 1'b1;
    logic [1:0]  wb_adr_i    = '0;
    logic [31:0] wb_dat_i    = '0;
    logic        wb_we_i     = 1'b0;
    logic        wb_cyc_i    = 1'b0;
    logic        wb_stb_i    = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;
    logic        sw_rst_o;

    clk_mon #(
        .GATE_CYCLES  (GATE),
        .CNT_W        (CNT_W),
        .SWRST_CYCLES (SWRST)
    ) dut (
        .wb_clk_o    (wb_clk_o),
        .async_rst_o (async_rst_o),
        .meas_clk_i  (meas_clk_i),
        .locked_i    (locked_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .irq_o       (irq_o),
        .sw_rst_o    (sw_rst_o)
    );

    // Measured clock at exactly twice the bus clock.
    always #10 wb_clk_o   = ~wb_clk_o;
    always #5  meas_clk_i = ~meas_clk_i;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
        int          tol;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_FREQ   = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_ID     = 2'd3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack was sampled.
    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                           input string tag);
        bit   got;
        exp_t e;
        logic [31:0] lo;
        logic [31:0] hi;
        bit   in_rng;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge wb_clk_o);
            if (wb_ack_o === 1'b1) got = 1'b1;
        end
        if (got && !we && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (e.tol == 0) begin
                assert ((wb_dat_o & e.mask) === (e.exp & e.mask)) else begin
                    n_errors++;
                    $error("FAIL %s: observed=0x%08h expected=0x%08h mask=0x%08h",
                           e.tag, wb_dat_o, e.exp, e.mask);
                end
            end else begin
                lo = e.exp - 32'(e.tol);
                hi = e.exp + 32'(e.tol);
                in_rng = (wb_dat_o >= lo) && (wb_dat_o <= hi);
                assert (in_rng === 1'b1) else begin
                    n_errors++;
                    $error("FAIL %s: observed=%0d expected=%0d..%0d", e.tag, wb_dat_o, lo, hi);
                end
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=no_ack expected=ack within 16 cycles", tag);
            if (!we && sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input logic [31:0] mask,
                      input int tol, input string tag);
        exp_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        e.tol  = tol;
        sb.push_back(e);
        wb_xfer(1'b0, adr, 32'd0, tag);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input string tag);
        wb_xfer(1'b1, adr, dat, tag);
    endtask

    task automatic lose_lock();
        locked_i = 1'b0;
        repeat (4) @(negedge wb_clk_o);
        locked_i = 1'b1;
        repeat (4) @(negedge wb_clk_o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // Reset state
        repeat (3) @(negedge wb_clk_o);
        chk("rst_ack",  {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat",  wb_dat_o,          32'd0);
        chk("rst_irq",  {31'd0, irq_o},    32'd0);
        chk("rst_swrst",{31'd0, sw_rst_o}, 32'd0);
        async_rst_o = 1'b0;
        repeat (4) @(negedge wb_clk_o);
        rd(A_FREQ,   32'd0,         32'hFFFF_FFFF, 0, "freq_reset");
        rd(A_STATUS, 32'h0000_0001, 32'hFFFF_FFFF, 0, "status_reset");
        rd(A_ID,     32'h434B4D31,  32'hFFFF_FFFF, 0, "id");

        // Held request: ack must alternate 0,1,0,1,0,1
        @(negedge wb_clk_o);
        wb_adr_i = A_ID;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ack_toggle_%0d", i), {31'd0, wb_ack_o}, 32'(i % 2));
            if (i % 2 == 1) chk($sformatf("ack_id_%0d", i), wb_dat_o, 32'h434B4D31);
            @(negedge wb_clk_o);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge wb_clk_o);

        // Between first and second window end: no result yet
        repeat (1100) @(negedge wb_clk_o);
        rd(A_FREQ,   32'd0, 32'hFFFF_FFFF, 0, "freq_one_window");
        rd(A_STATUS, 32'd0, 32'h0000_0002, 0, "fvalid_one_window");
        repeat (1000) @(negedge wb_clk_o);
        rd(A_FREQ,   32'(2 * GATE), 32'hFFFF_FFFF, 1, "freq_2x");
        rd(A_STATUS, 32'h0000_0002, 32'h0000_0002, 0, "fvalid_set");
        wr(A_FREQ, 32'h0000_FFFF, "wr_ro_freq");
        rd(A_FREQ,   32'(2 * GATE), 32'hFFFF_FFFF, 1, "freq_ro");

        // Lock loss with latency bounds, then two more
        locked_i = 1'b0;
        @(negedge wb_clk_o);
        chk("irq_not_early", {31'd0, irq_o}, 32'd0);
        repeat (3) @(negedge wb_clk_o);
        chk("irq_latency", {31'd0, irq_o}, 32'd1);
        locked_i = 1'b1;
        repeat (4) @(negedge wb_clk_o);
        lose_lock();
        lose_lock();
        rd(A_STATUS, 32'h0000_0304, 32'h0000_FF04, 0, "loss3");
        chk("irq_after_loss3", {31'd0, irq_o}, 32'd1);
        wr(A_STATUS, 32'h0000_0004, "w1c");
        chk("irq_w1c", {31'd0, irq_o}, 32'd0);
        rd(A_STATUS, 32'h0000_0300, 32'h0000_FF04, 0, "loss_keep");

        // Soft reset pulse length
        wr(A_CTRL, 32'd1, "ctrl_go");
        cnt = 0;
        while (sw_rst_o === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge wb_clk_o);
        end
        chk("swrst_len", 32'(cnt), 32'(SWRST));

        // Rewrite 10 cycles in extends the pulse to 10 + SWRST
        wr(A_CTRL, 32'd1, "ctrl_go2");
        cnt = (sw_rst_o === 1'b1) ? 1 : 0;
        repeat (9) begin
            @(negedge wb_clk_o);
            if (sw_rst_o === 1'b1) cnt++;
        end
        wr(A_CTRL, 32'd1, "ctrl_extend");
        while (sw_rst_o === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge wb_clk_o);
        end
        chk("swrst_extended", 32'(cnt), 32'(10 + SWRST));

        wr(A_CTRL, 32'd1, "ctrl_go3");
        rd(A_STATUS, 32'h0000_0008, 32'h0000_0008, 0, "swrst_status_on");
        rd(A_CTRL,   32'd0,         32'hFFFF_FFFF, 0, "ctrl_reads0");
        repeat (20) @(negedge wb_clk_o);
        rd(A_STATUS, 32'h0000_0000, 32'h0000_0008, 0, "swrst_status_off");

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) lose_lock();
        rd(A_STATUS, 32'h0000_FF04, 32'h0000_FF04, 0, "loss_sat");

        // W1C landing on the same edge as a new loss: set wins
        wr(A_STATUS, 32'h0000_0004, "w1c_pre");
        chk("irq_cleared_pre", {31'd0, irq_o}, 32'd0);
        locked_i = 1'b0;
        repeat (2) @(negedge wb_clk_o);
        wr(A_STATUS, 32'h0000_0004, "w1c_collide");
        chk("irq_set_wins", {31'd0, irq_o}, 32'd1);
        locked_i = 1'b1;
        repeat (4) @(negedge wb_clk_o);
        rd(A_STATUS, 32'h0000_FF04, 32'h0000_FF04, 0, "irq_pending_kept");

        // Async reset mid-pulse and mid-window
        wr(A_CTRL, 32'd1, "ctrl_pre_rst");
        repeat (3) @(negedge wb_clk_o);
        #3 async_rst_o = 1'b1;
        @(negedge wb_clk_o);
        chk("arst_swrst", {31'd0, sw_rst_o}, 32'd0);
        chk("arst_irq",   {31'd0, irq_o},    32'd0);
        chk("arst_ack",   {31'd0, wb_ack_o}, 32'd0);
        chk("arst_dat",   wb_dat_o,          32'd0);
        async_rst_o = 1'b0;
        repeat (4) @(negedge wb_clk_o);
        rd(A_FREQ,   32'd0, 32'hFFFF_FFFF, 0, "arst_freq");
        rd(A_STATUS, 32'd0, 32'h0000_FF0E, 0, "arst_status");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
